// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file writeback arbiter.
// Optional WB_ARB_BYPASS_EN build lets an idle arbiter write an accepted request straight to the port.
package regfile_pkg;

  localparam int WORD_WIDTH    = 32;
  localparam int ADDRESS_WIDTH = 5;
  localparam int NUM_REGS      = 1 << ADDRESS_WIDTH;

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0]    data;
  } wb_req_t;

  typedef enum logic {
    SRC_ALU  = 1'b0,
    SRC_LOAD = 1'b1
  } src_e;

  // Relative age of the two slots; only meaningful while both are full.
  typedef enum logic [1:0] {
    AGE_SAME     = 2'd0,
    AGE_S0_OLDER = 2'd1,
    AGE_S1_OLDER = 2'd2
  } age_e;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDRESS_WIDTH-1:0] a);
    logic [NUM_REGS-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus between the two writeback sources, the arbiter and the register-file write port.
// Handshake: a write transfers at a rising edge where reqN_valid & reqN_ready; ready depends only on registered state.
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic                     req0_valid;
  logic                     req0_ready;
  logic [ADDRESS_WIDTH-1:0] req0_addr;
  logic [WORD_WIDTH-1:0]    req0_data;
  logic                     req1_valid;
  logic                     req1_ready;
  logic [ADDRESS_WIDTH-1:0] req1_addr;
  logic [WORD_WIDTH-1:0]    req1_data;
  logic [ADDRESS_WIDTH-1:0] WA3;
  logic [WORD_WIDTH-1:0]    WD3;
  logic                     WEN;
  logic                     grant_id;
  logic [NUM_REGS-1:0]      pending_mask;
  age_e                     dbg_age;

  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready, WA3, WD3, WEN, grant_id, pending_mask, dbg_age
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready, WA3, WD3, WEN, grant_id, pending_mask, dbg_age
  );

endinterface

// File: rtl/wb_hold_slot.sv
// One-entry writeback holding buffer; writes to x0 complete the handshake but never fill.
module wb_hold_slot
  import regfile_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    in_valid,
  input  wb_req_t in_req,
  input  logic    bypass,
  input  logic    drain,
  output logic    ready,
  output logic    full,
  output logic    fill,
  output wb_req_t req
);

  logic    full_q, full_d;
  wb_req_t req_q, req_d;

  assign ready = ~full_q;
  assign full  = full_q;
  assign req   = req_q;

  always_comb begin
    full_d = full_q;
    req_d  = req_q;
    fill   = in_valid & ~full_q & (in_req.addr != '0) & ~bypass;
    if (drain) full_d = 1'b0;
    if (fill) begin
      full_d = 1'b1;
      req_d  = in_req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      req_q  <= '0;
    end else begin
      full_q <= full_d;
      req_q  <= req_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Oldest-first, round-robin-on-tie arbiter sharing the register file write port between two sources.
// Build option WB_ARB_BYPASS_EN: requests accepted into an idle arbiter skip the slots (1-edge latency).
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  regfile_wb_arbiter_if.slave bus
);

  wb_req_t req0_in, req1_in, slot0_req, slot1_req;
  logic    slot0_ready, slot1_ready, slot0_full, slot1_full, slot0_fill, slot1_fill;
  logic    drain0, drain1, byp0, byp1;

  age_e                     age_q, age_d;
  src_e                     rr_q, rr_d, gid_q, gid_d;
  logic                     wen_q, wen_d;
  logic [ADDRESS_WIDTH-1:0] wa3_q, wa3_d;
  logic [WORD_WIDTH-1:0]    wd3_q, wd3_d;
  logic [NUM_REGS-1:0]      mask;

  assign req0_in = {bus.req0_addr, bus.req0_data};
  assign req1_in = {bus.req1_addr, bus.req1_data};

  wb_hold_slot u_slot0 (
    .clk(clk), .rst(rst), .in_valid(bus.req0_valid), .in_req(req0_in), .bypass(byp0),
    .drain(drain0), .ready(slot0_ready), .full(slot0_full), .fill(slot0_fill), .req(slot0_req)
  );

  wb_hold_slot u_slot1 (
    .clk(clk), .rst(rst), .in_valid(bus.req1_valid), .in_req(req1_in), .bypass(byp1),
    .drain(drain1), .ready(slot1_ready), .full(slot1_full), .fill(slot1_fill), .req(slot1_req)
  );

`ifdef WB_ARB_BYPASS_EN
  logic want0, want1;
  assign want0 = bus.req0_valid & slot0_ready & (bus.req0_addr != '0);
  assign want1 = bus.req1_valid & slot1_ready & (bus.req1_addr != '0);
`endif

  // Grant selection and write-port next state.
  always_comb begin
    rr_d   = rr_q;
    drain0 = 1'b0;
    drain1 = 1'b0;
    byp0   = 1'b0;
    byp1   = 1'b0;
    wen_d  = 1'b0;
    wa3_d  = wa3_q;
    wd3_d  = wd3_q;
    gid_d  = gid_q;
    if (slot0_full && slot1_full) begin
      case (age_q)
        AGE_S0_OLDER: drain0 = 1'b1;
        AGE_S1_OLDER: drain1 = 1'b1;
        default: begin
          if (rr_q == SRC_ALU) drain0 = 1'b1;
          else                 drain1 = 1'b1;
          rr_d = (rr_q == SRC_ALU) ? SRC_LOAD : SRC_ALU;
        end
      endcase
    end else if (slot0_full) begin
      drain0 = 1'b1;
    end else if (slot1_full) begin
      drain1 = 1'b1;
    end
`ifdef WB_ARB_BYPASS_EN
    else if (want0 && want1) begin
      if (rr_q == SRC_ALU) byp0 = 1'b1;
      else                 byp1 = 1'b1;
      rr_d = (rr_q == SRC_ALU) ? SRC_LOAD : SRC_ALU;
    end else if (want0) begin
      byp0 = 1'b1;
    end else if (want1) begin
      byp1 = 1'b1;
    end
`endif
    if (drain0) begin
      wen_d = 1'b1; wa3_d = slot0_req.addr; wd3_d = slot0_req.data; gid_d = SRC_ALU;
    end else if (drain1) begin
      wen_d = 1'b1; wa3_d = slot1_req.addr; wd3_d = slot1_req.data; gid_d = SRC_LOAD;
    end else if (byp0) begin
      wen_d = 1'b1; wa3_d = bus.req0_addr; wd3_d = bus.req0_data; gid_d = SRC_ALU;
    end else if (byp1) begin
      wen_d = 1'b1; wa3_d = bus.req1_addr; wd3_d = bus.req1_data; gid_d = SRC_LOAD;
    end
  end

  // A slot that fills next to a slot that stays full is the younger one.
  always_comb begin
    age_d = age_q;
    if (slot0_fill && slot1_fill)                 age_d = AGE_SAME;
    else if (slot0_fill && slot1_full && !drain1) age_d = AGE_S1_OLDER;
    else if (slot1_fill && slot0_full && !drain0) age_d = AGE_S0_OLDER;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      age_q <= AGE_SAME;
      rr_q  <= SRC_ALU;
      gid_q <= SRC_ALU;
      wen_q <= 1'b0;
      wa3_q <= '0;
      wd3_q <= '0;
    end else begin
      age_q <= age_d;
      rr_q  <= rr_d;
      gid_q <= gid_d;
      wen_q <= wen_d;
      wa3_q <= wa3_d;
      wd3_q <= wd3_d;
    end
  end

  always_comb begin
    mask = '0;
    if (slot0_full) mask = mask | reg_onehot(slot0_req.addr);
    if (slot1_full) mask = mask | reg_onehot(slot1_req.addr);
    if (wen_q)      mask = mask | reg_onehot(wa3_q);
    mask[0] = 1'b0;
  end

  assign bus.req0_ready   = slot0_ready;
  assign bus.req1_ready   = slot1_ready;
  assign bus.WA3          = wa3_q;
  assign bus.WD3          = wd3_q;
  assign bus.WEN          = wen_q;
  assign bus.grant_id     = gid_q;
  assign bus.pending_mask = mask;
  assign bus.dbg_age      = age_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand-written reset sequences, random traffic vs a model.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int AW = ADDRESS_WIDTH;
  localparam int WW = WORD_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic                r0;
    logic                r1;
    logic                wen;
    logic [AW-1:0]       wa3;
    logic [WW-1:0]       wd3;
    logic                gid;
    logic [NUM_REGS-1:0] mask;
  } obs_t;

  typedef struct packed {
    logic          v0;
    logic [AW-1:0] a0;
    logic [WW-1:0] d0;
    logic          v1;
    logic [AW-1:0] a1;
    logic [WW-1:0] d1;
    obs_t          exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  // ---------------- scoreboard ----------------
  function automatic obs_t mk(logic r0, logic r1, logic wen, logic [AW-1:0] wa, logic [WW-1:0] wd,
                              logic gid, logic [NUM_REGS-1:0] mask);
    obs_t o;
    o.r0 = r0; o.r1 = r1; o.wen = wen; o.wa3 = wa; o.wd3 = wd; o.gid = gid; o.mask = mask;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(bus.req0_ready, bus.req1_ready, bus.WEN, bus.WA3, bus.WD3, bus.grant_id, bus.pending_mask);
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = sample();
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got r0=%0b r1=%0b wen=%0b wa3=%0d wd3=%h gid=%0b mask=%h (age=%0d), want r0=%0b r1=%0b wen=%0b wa3=%0d wd3=%h gid=%0b mask=%h",
               name, act.r0, act.r1, act.wen, act.wa3, act.wd3, act.gid, act.mask, bus.dbg_age,
               exp.r0, exp.r1, exp.wen, exp.wa3, exp.wd3, exp.gid, exp.mask);
    end
  endtask

  function automatic void add(logic v0, logic [AW-1:0] a0, logic [WW-1:0] d0,
                              logic v1, logic [AW-1:0] a1, logic [WW-1:0] d1, obs_t exp);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1; v.exp = exp;
    vecs.push_back(v);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [WW-1:0] d0,
                       input logic v1, input logic [AW-1:0] a1, input logic [WW-1:0] d1);
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
  endtask

  // ---------------- reference model ----------------
  // Each held write carries the cycle it was accepted; the smallest stamp commits first.
  logic          m_full[2];
  logic [AW-1:0] m_addr[2];
  logic [WW-1:0] m_data[2];
  int            m_ts[2];
  int            m_rr;
  int            m_cyc;
  logic          m_wen;
  logic [AW-1:0] m_wa;
  logic [WW-1:0] m_wd;
  logic          m_gid;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 1'b0; m_addr[i] = '0; m_data[i] = '0; m_ts[i] = 0;
    end
    m_rr = 0; m_cyc = 0; m_wen = 1'b0; m_wa = '0; m_wd = '0; m_gid = 1'b0;
  endtask

  function automatic obs_t model_obs();
    logic [NUM_REGS-1:0] mask;
    mask = '0;
    for (int i = 0; i < 2; i++) if (m_full[i]) mask[m_addr[i]] = 1'b1;
    if (m_wen) mask[m_wa] = 1'b1;
    mask[0] = 1'b0;
    return mk(!m_full[0], !m_full[1], m_wen, m_wa, m_wd, m_gid, mask);
  endfunction

  task automatic model_edge(input logic v0, input logic [AW-1:0] a0, input logic [WW-1:0] d0,
                            input logic v1, input logic [AW-1:0] a1, input logic [WW-1:0] d1);
    logic          acc[2];
    logic [AW-1:0] ia[2];
    logic [WW-1:0] id[2];
    int            g;
`ifdef WB_ARB_BYPASS_EN
    int            b;
`endif
    ia[0] = a0; ia[1] = a1; id[0] = d0; id[1] = d1;
    acc[0] = v0 && !m_full[0] && (a0 != 0);
    acc[1] = v1 && !m_full[1] && (a1 != 0);
    g = -1;
    if (m_full[0] && m_full[1]) begin
      if (m_ts[0] < m_ts[1])      g = 0;
      else if (m_ts[1] < m_ts[0]) g = 1;
      else begin
        g = m_rr;
        m_rr = 1 - m_rr;
      end
    end else if (m_full[0]) g = 0;
    else if (m_full[1]) g = 1;
    m_wen = 1'b0;
    if (g >= 0) begin
      m_wen = 1'b1; m_wa = m_addr[g]; m_wd = m_data[g]; m_gid = g[0]; m_full[g] = 1'b0;
    end
`ifdef WB_ARB_BYPASS_EN
    else if (acc[0] || acc[1]) begin
      if (acc[0] && acc[1]) begin
        b = m_rr;
        m_rr = 1 - m_rr;
      end else begin
        b = acc[0] ? 0 : 1;
      end
      m_wen = 1'b1; m_wa = ia[b]; m_wd = id[b]; m_gid = b[0]; acc[b] = 1'b0;
    end
`endif
    for (int i = 0; i < 2; i++) begin
      if (acc[i]) begin
        m_full[i] = 1'b1; m_addr[i] = ia[i]; m_data[i] = id[i]; m_ts[i] = m_cyc;
      end
    end
    m_cyc++;
  endtask

  task automatic step(input string name, input logic v0, input logic [AW-1:0] a0, input logic [WW-1:0] d0,
                      input logic v1, input logic [AW-1:0] a1, input logic [WW-1:0] d1);
    drive(v0, a0, d0, v1, a1, d1);
    model_edge(v0, a0, d0, v1, a1, d1);
    @(posedge clk);
    #1;
    check(name, model_obs());
  endtask

  // Asynchronous reset pulse in the middle of a cycle; outputs must clear before the next edge.
  task automatic pulse_reset(input string name);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check(name, mk(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0));
    rst = 1'b0;
  endtask

  task automatic fill_table();
`ifdef WB_ARB_BYPASS_EN
    add(1, 9, 32'h55, 0, 0, 0, mk(1, 1, 1, 9, 32'h55, 0, 32'h0000_0200));
    add(0, 0, 0,      0, 0, 0, mk(1, 1, 0, 9, 32'h55, 0, 32'h0));
    add(1, 0, 32'hFFFF, 0, 0, 0, mk(1, 1, 0, 9, 32'h55, 0, 32'h0));
`else
    add(1, 5, 32'hDEADBEEF, 0, 0, 0, mk(0, 1, 0, 0, 32'h0, 0, 32'h0000_0020));
    add(0, 0, 0, 0, 0, 0,            mk(1, 1, 1, 5, 32'hDEADBEEF, 0, 32'h0000_0020));
    add(0, 0, 0, 0, 0, 0,            mk(1, 1, 0, 5, 32'hDEADBEEF, 0, 32'h0));
    add(1, 3, 32'h11, 1, 4, 32'h22,  mk(0, 0, 0, 5, 32'hDEADBEEF, 0, 32'h0000_0018));
    add(0, 0, 0, 0, 0, 0,            mk(1, 0, 1, 3, 32'h11, 0, 32'h0000_0018));
    add(0, 0, 0, 0, 0, 0,            mk(1, 1, 1, 4, 32'h22, 1, 32'h0000_0010));
    add(0, 0, 0, 0, 0, 0,            mk(1, 1, 0, 4, 32'h22, 1, 32'h0));
    add(1, 10, 32'h33, 1, 11, 32'h44, mk(0, 0, 0, 4, 32'h22, 1, 32'h0000_0C00));
    add(0, 0, 0, 0, 0, 0,            mk(0, 1, 1, 11, 32'h44, 1, 32'h0000_0C00));
    add(0, 0, 0, 0, 0, 0,            mk(1, 1, 1, 10, 32'h33, 0, 32'h0000_0400));
    add(0, 0, 0, 0, 0, 0,            mk(1, 1, 0, 10, 32'h33, 0, 32'h0));
    add(0, 0, 0, 1, 7, 32'hAA,       mk(1, 0, 0, 10, 32'h33, 0, 32'h0000_0080));
    add(1, 7, 32'hBB, 0, 0, 0,       mk(0, 1, 1, 7, 32'hAA, 1, 32'h0000_0080));
    add(0, 0, 0, 0, 0, 0,            mk(1, 1, 1, 7, 32'hBB, 0, 32'h0000_0080));
    add(0, 0, 0, 0, 0, 0,            mk(1, 1, 0, 7, 32'hBB, 0, 32'h0));
    add(1, 0, 32'hFFFF, 0, 0, 0,     mk(1, 1, 0, 7, 32'hBB, 0, 32'h0));
    add(1, 0, 32'hFFFF, 0, 0, 0,     mk(1, 1, 0, 7, 32'hBB, 0, 32'h0));
    add(0, 0, 0, 0, 0, 0,            mk(1, 1, 0, 7, 32'hBB, 0, 32'h0));
`endif
  endtask

  // ---------------- main ----------------
  initial begin
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    fill_table();
    #12;
    check("reset", mk(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0));
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    pulse_reset("rst_before_seq");
    step("both_accept", 1, 6, 32'h66, 1, 8, 32'h88);
    pulse_reset("rst_slots_full");
    for (int i = 0; i < 3; i++) step("after_rst_idle", 0, 0, 0, 0, 0, 0);
    step("both_accept2", 1, 6, 32'h66, 1, 8, 32'h88);
    step("first_commit", 0, 0, 0, 0, 0, 0);
    pulse_reset("rst_wen_high");
    for (int i = 0; i < 3; i++) step("after_rst_idle2", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      step("rand",
           $urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), WW'($urandom),
           $urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), WW'($urandom));
      if ($urandom_range(0, 63) == 0) pulse_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port (WA3/WD3/WEN) between two writeback requesters: req0 for the ALU/execute path and req1 for the load/multi-cycle path. Each source has a one-entry holding slot with a valid/ready handshake. Writes commit oldest-first, and ties are broken round-robin. A pending-register mask goes to the hazard/stall logic. The block sits between the writeback sources and the register file's write port.

Parameters:
WORD_WIDTH, 32, data width of a register
ADDRESS_WIDTH, 5, register index width; the register file has 2**ADDRESS_WIDTH entries

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  source 0 has a write to offer
req0_ready  output  1  source 0 slot can accept a write
req0_addr  input  ADDRESS_WIDTH  source 0 destination register
req0_data  input  WORD_WIDTH  source 0 write data
req1_valid  input  1  source 1 has a write to offer
req1_ready  output  1  source 1 slot can accept a write
req1_addr  input  ADDRESS_WIDTH  source 1 destination register
req1_data  input  WORD_WIDTH  source 1 write data
WA3  output  ADDRESS_WIDTH  register file write address, registered
WD3  output  WORD_WIDTH  register file write data, registered
WEN  output  1  register file write enable, registered
grant_id  output  1  source of the current WEN beat (0 or 1)
pending_mask  output  2**ADDRESS_WIDTH  bit r = 1 while a write to register r is held or on the port

Behaviour:
- Reset (async, rst=1) clears the following immediately:
  - both slots empty; reqN_ready = 1
  - WEN = 0, WA3 = 0, WD3 = 0, grant_id = 0
  - pending_mask = 0; round-robin pointer selects req0 first
  - any in-flight write is dropped
- Accept: a slot fills at the rising edge where reqN_valid & reqN_ready.
  - reqN_ready = ~slotN_full, registered-state based.
  - There is no same-cycle refill: ready re-asserts the cycle after the slot drains.
- Address 0: the handshake completes, but the slot does not fill and nothing is ever written.
- Age tracking:
  - If a slot fills while the other slot is already full, the other slot is older.
  - If both fill at the same edge, they are the same age.
- Arbitration each cycle, among full slots:
  - oldest first
  - same age: the slot the round-robin pointer selects; the pointer then flips to the other source
- Commit: the granted slot is copied into WA3/WD3 with WEN=1 and grant_id=N at the edge; the slot empties at the same edge.
  - With no grant, WEN=0 the next cycle; WA3/WD3 hold their last values.
- Latency, default build:
  - accept edge E0
  - WEN high during the cycle after E1
  - register file writes at E2
  - minimum 2 edges from accept to WEN
- Throughput: one write per cycle. Each source sustains one write per 2 cycles.
- Same-address writes from both sources commit in age order, so the younger write wins in the register file.
- pending_mask:
  - OR of decoded slot0 addr (if full), slot1 addr (if full), and WA3 (if WEN)
  - combinational from registered state
  - bit 0 is always 0
- Simultaneous accept and grant on the same slot cannot occur, because ready=0 while full.

Optional Feature:
Macro WB_ARB_BYPASS_EN.
- Defined: a request accepted while both slots are empty, and not contending with the other source in that cycle, is written directly into WA3/WD3/WEN at the accept edge. Accept-to-WEN latency becomes 1 edge and the slot stays empty. When both sources are accepted at the same edge with both slots empty, the round-robin winner bypasses and the other fills its slot and becomes older.
- Undefined: all writes pass through the slots (2-edge latency).

Decomposition:
- Package regfile_pkg holds:
  - localparams WORD_WIDTH=32, ADDRESS_WIDTH=5, NUM_REGS
  - typedef wb_req_t, a struct of addr and data
  - typedef enum src_e {SRC_ALU=0, SRC_LOAD=1}
- Sub-module wb_hold_slot is the one-entry holding buffer: full flag, wb_req_t payload, accept/drain, x0 discard. It is instantiated twice.
- The arbitration, age bit, output register and mask decode live in the top-level module.

Test Plan:
- Reset, then req0 writes x5=0xDEADBEEF at E0 → req0_ready=0 for 1 cycle; WEN=1, WA3=5, WD3=0xDEADBEEF, grant_id=0 after E1; pending_mask[5]=1 from E0 until WEN drops.
- req0 x3=0x11 and req1 x4=0x22 accepted at the same edge, pointer at 0 → WEN beats x3 (grant 0) then x4 (grant 1); the next tie grants req1 first.
- req1 x7=0xAA accepted at E0, req0 x7=0xBB accepted at E1 → commit order 0xAA then 0xBB; final x7=0xBB.
- req0 valid with addr 0, data 0xFFFF → ready stays 1, WEN never asserts, pending_mask stays 0.
- Both slots full and rst pulsed mid-cycle → WEN=0, both readies=1 and pending_mask=0 immediately; no write from those slots afterwards.
- WB_ARB_BYPASS_EN defined: req0 x9=0x55 with idle arbiter → WEN=1, WA3=9 right after the accept edge; undefined → one cycle later.
